// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chess_pkg
//  Description : Shared definitions for the knight move generator: piece
//                codes, colour-bit position, knight direction codes and
//                their (dRow, dCol) offsets, and the scan state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package chess_pkg;

  // Square layout: bit3 = colour, bits[2:0] = piece type.
  localparam int COLOUR_BIT = 3;
  localparam int TYPE_W     = 3;

  typedef enum logic [2:0] {
    PT_EMPTY  = 3'd0,
    PT_PAWN   = 3'd1,
    PT_KNIGHT = 3'd2,
    PT_BISHOP = 3'd3,
    PT_ROOK   = 3'd4,
    PT_QUEEN  = 3'd5,
    PT_KING   = 3'd6
  } piece_t;

  typedef enum logic [2:0] {
    DIR_UPLEFTLEFT     = 3'd0,
    DIR_UPUPLEFT       = 3'd1,
    DIR_UPUPRIGHT      = 3'd2,
    DIR_UPRIGHTRIGHT   = 3'd3,
    DIR_RIGHTRIGHTDOWN = 3'd4,
    DIR_RIGHTDOWNDOWN  = 3'd5,
    DIR_LEFTDOWNDOWN   = 3'd6,
    DIR_LEFTLEFTDOWN   = 3'd7
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Row offset for each knight direction ("up" = row+1).
  function automatic logic signed [3:0] knight_drow(input logic [2:0] dir);
    logic signed [3:0] d;
    case (dir)
      DIR_UPLEFTLEFT:     d = 4'sd1;
      DIR_UPUPLEFT:       d = 4'sd2;
      DIR_UPUPRIGHT:      d = 4'sd2;
      DIR_UPRIGHTRIGHT:   d = 4'sd1;
      DIR_RIGHTRIGHTDOWN: d = -4'sd1;
      DIR_RIGHTDOWNDOWN:  d = -4'sd2;
      DIR_LEFTDOWNDOWN:   d = -4'sd2;
      default:            d = -4'sd1;
    endcase
    return d;
  endfunction

  // Column offset for each knight direction.
  function automatic logic signed [3:0] knight_dcol(input logic [2:0] dir);
    logic signed [3:0] d;
    case (dir)
      DIR_UPLEFTLEFT:     d = -4'sd2;
      DIR_UPUPLEFT:       d = -4'sd1;
      DIR_UPUPRIGHT:      d = 4'sd1;
      DIR_UPRIGHTRIGHT:   d = 4'sd2;
      DIR_RIGHTRIGHTDOWN: d = 4'sd2;
      DIR_RIGHTDOWNDOWN:  d = 4'sd1;
      DIR_LEFTDOWNDOWN:   d = -4'sd1;
      default:            d = -4'sd2;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/knight_target.sv
`default_nettype none
// ============================================================================
//  Module      : knight_target
//  Description : Combinational landing-square calculator for one knight
//                direction from a source square.
//  Ports       : currentPosition [5:0]  source square
//                dir             [2:0]  knight direction code
//                targetSq        [5:0]  landing square (valid when onBoard)
//                onBoard                landing square lies on the board
//  Revision    : 1.0  initial release
// ============================================================================
module knight_target
  import chess_pkg::*;
(
  input  logic [5:0] currentPosition,
  input  logic [2:0] dir,
  output logic [5:0] targetSq,
  output logic       onBoard
);

  logic signed [3:0] row_w;
  logic signed [3:0] col_w;

  assign row_w = $signed({1'b0, currentPosition[5:3]}) + knight_drow(dir);
  assign col_w = $signed({1'b0, currentPosition[2:0]}) + knight_dcol(dir);

  // Source coordinates are 0..7 and offsets are -2..+2, so results span
  // -2..9. In signed 4-bit, every value in 0..7 has bit3 clear, while
  // negatives and the 8/9 overflow both land with bit3 set.
  assign onBoard  = ~row_w[3] & ~col_w[3];
  assign targetSq = {row_w[2:0], col_w[2:0]};

endmodule
`default_nettype wire

// File: rtl/knight_move_gen.sv
`default_nettype none
// ============================================================================
//  Module      : knight_move_gen
//  Description : Walks the 8 knight directions from a latched source square,
//                one per cycle, streams legal destinations over valid/ready
//                and accumulates move/capture masks and a move count.
//  Ports       : clk, reset           clock, synchronous active-high reset
//                start                scan request (honoured only when idle)
//                bigBoard             flat board, square i at [4i+3:4i]
//                currentPosition      source square
//                busy                 scan in progress
//                moveValid/moveReady  move handshake
//                moveTo/moveCapture/movePiece  presented move fields
//                done                 one-cycle completion pulse
//                moveMask/captureMask/moveCount  scan results
//  Revision    : 1.0  initial release
// ============================================================================
module knight_move_gen
  import chess_pkg::*;
#(
  parameter int SQ_W = 6,
  parameter int PC_W = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [(1<<SQ_W)*PC_W-1:0]      bigBoard,
  input  logic [SQ_W-1:0]                currentPosition,
  output logic                           busy,
  output logic                           moveValid,
  input  logic                           moveReady,
  output logic [SQ_W-1:0]                moveTo,
  output logic                           moveCapture,
  output logic [2:0]                     movePiece,
  output logic                           done,
  output logic [(1<<SQ_W)-1:0]           moveMask,
  output logic [(1<<SQ_W)-1:0]           captureMask,
  output logic [3:0]                     moveCount
);

  localparam int NSQ     = 1 << SQ_W;
  localparam int BOARD_W = NSQ * PC_W;
  localparam int IDX_W   = $clog2(BOARD_W);

  state_t               state_q, state_d;
  logic [2:0]           dir_q, dir_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic [SQ_W-1:0]      pos_q, pos_d;
  logic [SQ_W-1:0]      move_to_q, move_to_d;
  logic                 move_cap_q, move_cap_d;
  logic [2:0]           move_piece_q, move_piece_d;
  logic [NSQ-1:0]       move_mask_q, move_mask_d;
  logic [NSQ-1:0]       cap_mask_q, cap_mask_d;
  logic [3:0]           move_count_q, move_count_d;

  logic [SQ_W-1:0]      tgt_sq_w;
  logic                 on_board_w;
  logic [IDX_W-1:0]     tgt_base_w;
  logic [IDX_W-1:0]     src_colour_idx_w;
  logic [IDX_W-1:0]     in_base_w;
  logic [PC_W-1:0]      tgt_piece_w;
  logic                 src_colour_w;
  logic [TYPE_W-1:0]    in_type_w;
  logic                 tgt_occupied_w;
  logic                 skip_w;
  logic [NSQ-1:0]       tgt_onehot_w;

  knight_target u_knight_target (
    .currentPosition (pos_q),
    .dir             (dir_q),
    .targetSq        (tgt_sq_w),
    .onBoard         (on_board_w)
  );

  assign tgt_base_w       = IDX_W'(32'(tgt_sq_w) * PC_W);
  assign src_colour_idx_w = IDX_W'(32'(pos_q) * PC_W + COLOUR_BIT);
  assign in_base_w        = IDX_W'(32'(currentPosition) * PC_W);

  assign tgt_piece_w  = board_q[tgt_base_w +: PC_W];
  assign src_colour_w = board_q[src_colour_idx_w];
  // Source occupancy is judged on the live board, at the moment start is taken.
  assign in_type_w    = bigBoard[in_base_w +: TYPE_W];

  assign tgt_occupied_w = (tgt_piece_w[TYPE_W-1:0] != PT_EMPTY);
  // A colour match only blocks when the target actually holds a piece.
  assign skip_w = ~on_board_w |
                  (tgt_occupied_w & (tgt_piece_w[COLOUR_BIT] == src_colour_w));
  assign tgt_onehot_w = NSQ'(1) << tgt_sq_w;

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    board_d      = board_q;
    pos_d        = pos_q;
    move_to_d    = move_to_q;
    move_cap_d   = move_cap_q;
    move_piece_d = move_piece_q;
    move_mask_d  = move_mask_q;
    cap_mask_d   = cap_mask_q;
    move_count_d = move_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          board_d      = bigBoard;
          pos_d        = currentPosition;
          move_mask_d  = '0;
          cap_mask_d   = '0;
          move_count_d = '0;
          dir_d        = '0;
          state_d      = (in_type_w == PT_EMPTY) ? DONE : SCAN;
        end
      end

      SCAN: begin
        if (skip_w) begin
          if (dir_q == DIR_LEFTLEFTDOWN) begin
            state_d = DONE;
          end else begin
            dir_d = dir_q + 3'd1;
          end
        end else begin
          move_to_d    = tgt_sq_w;
          move_cap_d   = tgt_occupied_w;
          // An empty square already reads as type 0.
          move_piece_d = tgt_piece_w[TYPE_W-1:0];
          move_mask_d  = move_mask_q | tgt_onehot_w;
          if (tgt_occupied_w) begin
            cap_mask_d = cap_mask_q | tgt_onehot_w;
          end
          move_count_d = move_count_q + 4'd1;
          state_d      = EMIT;
        end
      end

      EMIT: begin
        if (moveReady) begin
          if (dir_q == DIR_LEFTLEFTDOWN) begin
            state_d = DONE;
          end else begin
            dir_d   = dir_q + 3'd1;
            state_d = SCAN;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dir_q        <= '0;
      board_q      <= '0;
      pos_q        <= '0;
      move_to_q    <= '0;
      move_cap_q   <= 1'b0;
      move_piece_q <= '0;
      move_mask_q  <= '0;
      cap_mask_q   <= '0;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      board_q      <= board_d;
      pos_q        <= pos_d;
      move_to_q    <= move_to_d;
      move_cap_q   <= move_cap_d;
      move_piece_q <= move_piece_d;
      move_mask_q  <= move_mask_d;
      cap_mask_q   <= cap_mask_d;
      move_count_q <= move_count_d;
    end
  end

  assign busy        = (state_q == SCAN) || (state_q == EMIT);
  assign moveValid   = (state_q == EMIT);
  assign done        = (state_q == DONE);
  assign moveTo      = move_to_q;
  assign moveCapture = move_cap_q;
  assign movePiece   = move_piece_q;
  assign moveMask    = move_mask_q;
  assign captureMask = cap_mask_q;
  assign moveCount   = move_count_q;

endmodule
`default_nettype wire
